tsv_link_tx: RTL and testbench

Downstream neighbour of the layer-2 counter/flag partition. It takes parallel status words produced on layer 2 and serializes them over a narrow bundle of TSV lanes to layer 3. Flow control is credit-based, with per-beat odd parity and start-of-frame framing. It replaces one-TSV-per-bit crossings, which cost TSV area and power.

---
 rtl/tsv_link_pkg.sv | 27 ++
 rtl/tsv_credit_counter.sv | 50 +++++
 rtl/tsv_link_tx.sv | 113 +++++++++++
 tb/tb_tsv_link_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tsv_link_pkg.sv
// Shared types and sizing helpers for the layer-2 to layer-3 TSV link.
// Serializer state, default geometry and width functions.
package tsv_link_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_LANES   = 4;
   localparam int DEF_CREDITS = 2;

   function automatic int beats(input int data_w, input int lanes);
      return data_w / lanes;
   endfunction

   function automatic int credit_w(input int credits);
      return $clog2(credits + 1);
   endfunction

   // Counter width for 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tsv_credit_counter.sv
// Receiver-credit tracker for the TSV link.
// Up on returned credit, down on accepted frame, sticky overflow flag.
module tsv_credit_counter
   import tsv_link_pkg::*;
#(
   parameter int CREDITS = DEF_CREDITS,
   parameter int CW      = credit_w(DEF_CREDITS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          credit_i,
   input  logic          take_i,
   output logic [CW-1:0] cnt_o,
   output logic          avail_o,
   output logic          err_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= CW'(CREDITS);
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // A take is only issued when a credit is available, so no underflow.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (credit_i && !take_i) begin
         if (cnt_q == CW'(CREDITS)) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (take_i && !credit_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign cnt_o   = cnt_q;
   assign avail_o = (cnt_q != '0);
   assign err_o   = err_q;

endmodule

// File: rtl/tsv_link_tx.sv
// Credit-flow-controlled serializer of parallel words onto a TSV lane bundle.
// Framing with start-of-frame and per-beat odd parity.
module tsv_link_tx
   import tsv_link_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LANES   = DEF_LANES,
   parameter int CREDITS = DEF_CREDITS
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [LANES-1:0]  tsv_data,
   output logic              tsv_frame,
   output logic              tsv_sof,
   output logic              tsv_par,
   input  logic              tsv_credit,
   output logic [15:0]       frames_sent,
   output logic              err_credit,
   output logic              busy
);

   localparam int BEATS = beats(DATA_W, LANES);
   localparam int BW    = idx_w(BEATS);
   localparam int CW    = credit_w(CREDITS);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [15:0]       frames_q, frames_d;

   logic          credit_avail;
   logic [CW-1:0] credit_cnt;
   logic          last_beat;
   logic          accept;
   logic          sending;

   tsv_credit_counter #(
      .CREDITS (CREDITS),
      .CW      (CW)
   ) u_credit (
      .clk_i    (clk1),
      .rst_i    (rst),
      .credit_i (tsv_credit),
      .take_i   (accept),
      .cnt_o    (credit_cnt),
      .avail_o  (credit_avail),
      .err_o    (err_credit)
   );

   assign sending   = (state_q == SEND);
   assign last_beat = sending && (beat_q == BW'(BEATS - 1));
   assign in_ready  = credit_avail && ((state_q == IDLE) || last_beat);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         beat_q   <= '0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         beat_q   <= beat_d;
         frames_q <= frames_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      beat_d   = beat_q;
      frames_d = frames_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d = in_data;
               beat_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            shreg_d = shreg_q >> LANES;
            beat_d  = beat_q + 1'b1;
            if (last_beat) begin
               if (frames_q != 16'hFFFF) begin
                  frames_d = frames_q + 16'd1;
               end
               // A word accepted on the last beat follows with no gap.
               if (accept) begin
                  shreg_d = in_data;
                  beat_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line outputs come straight from state registers so reset blanks them at once.
   assign tsv_data    = sending ? shreg_q[LANES-1:0] : '0;
   assign tsv_frame   = sending;
   assign tsv_sof     = sending && (beat_q == '0);
   assign tsv_par     = sending && ~^shreg_q[LANES-1:0];
   assign frames_sent = frames_q;
   assign busy        = sending;

endmodule

// File: tb/tb_tsv_link_tx.sv
// Randomized and directed bench for tsv_link_tx.
// Expectations come from a beat-queue model of the link.
module tb_tsv_link_tx;

   localparam int DW  = 32;
   localparam int L   = 4;
   localparam int CR  = 2;
   localparam int NB  = DW / L;

   logic          clk1 = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [L-1:0]  tsv_data;
   logic          tsv_frame;
   logic          tsv_sof;
   logic          tsv_par;
   logic          tsv_credit;
   logic [15:0]   frames_sent;
   logic          err_credit;
   logic          busy;

   tsv_link_tx #(
      .DATA_W  (DW),
      .LANES   (L),
      .CREDITS (CR)
   ) dut (
      .clk1        (clk1),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .tsv_data    (tsv_data),
      .tsv_frame   (tsv_frame),
      .tsv_sof     (tsv_sof),
      .tsv_par     (tsv_par),
      .tsv_credit  (tsv_credit),
      .frames_sent (frames_sent),
      .err_credit  (err_credit),
      .busy        (busy)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      logic [L-1:0] d;
      bit           sof;
      bit           last;
   } beat_t;

   beat_t       q[$];
   int          m_cred;
   int          m_frames;
   bit          m_err;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit odd_par(input logic [L-1:0] x);
      return ($countones(x) % 2) == 0;
   endfunction

   function automatic bit m_ready();
      return (m_cred > 0) && (q.size() <= 1);
   endfunction

   task automatic m_reset();
      q.delete();
      m_cred   = CR;
      m_frames = 0;
      m_err    = 1'b0;
   endtask

   // One cycle: drive inputs, check outputs, advance model, cross posedge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
      bit    rdy;
      bit    acc;
      beat_t b;
      in_valid   = v;
      in_data    = d;
      tsv_credit = c;
      rdy = m_ready();
      #1;
      if (q.size() > 0) begin
         b = q[0];
         chk("frame", 32'(tsv_frame), 32'd1);
         chk("data", 32'(tsv_data), 32'(b.d));
         chk("sof", 32'(tsv_sof), 32'(b.sof));
         chk("par", 32'(tsv_par), 32'(odd_par(b.d)));
      end else begin
         chk("idle_frame", 32'(tsv_frame), 32'd0);
         chk("idle_data", 32'(tsv_data), 32'd0);
         chk("idle_sof", 32'(tsv_sof), 32'd0);
         chk("idle_par", 32'(tsv_par), 32'd0);
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("frames_sent", 32'(frames_sent), 32'(m_frames));
      chk("err_credit", 32'(err_credit), 32'(m_err));
      acc = v && rdy;
      if (q.size() > 0) begin
         b = q.pop_front();
         if (b.last && m_frames < 16'hFFFF) m_frames++;
      end
      if (acc) begin
         for (int i = 0; i < NB; i++) begin
            b.d    = d[i*L +: L];
            b.sof  = (i == 0);
            b.last = (i == NB - 1);
            q.push_back(b);
         end
      end
      if (c && !acc && m_cred == CR) m_err = 1'b1;
      else m_cred = m_cred + int'(c) - int'(acc);
      @(posedge clk1);
      @(negedge clk1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic give_credits();
      for (int i = 0; i < CR && m_cred < CR; i++) step(1'b0, '0, 1'b1);
   endtask

   task automatic send_one(input logic [DW-1:0] w);
      step(1'b1, w, 1'b0);
      idle(NB + 1);
      give_credits();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      tsv_credit = 1'b0;
      m_reset();
      repeat (3) @(negedge clk1);
      chk("rst_frames", 32'(frames_sent), 32'd0);
      chk("rst_frame", 32'(tsv_frame), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // Known-answer frame
      step(1'b1, 32'h8765_4321, 1'b0);
      idle(NB + 1);
      chk("kat_frames", 32'(frames_sent), 32'd1);
      give_credits();

      // Credit starvation with valid held
      for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0);
      chk("starved_ready", 32'(in_ready), 32'd0);
      step(1'b1, $urandom, 1'b1);
      for (int i = 0; i < NB + 2; i++) step(1'b1, $urandom, 1'b0);
      idle(NB + 2);
      give_credits();
      give_credits();

      // Credit returned on each accept cycle keeps frames gap-free
      for (int i = 0; i < 3 * NB; i++) step(1'b1, $urandom, m_ready());
      chk("b2b_cnt", 32'(dut.u_credit.cnt_q), 32'(m_cred));
      idle(NB + 2);

      // Spurious credit at full count
      step(1'b0, '0, 1'b1);
      idle(3);
      send_one($urandom);

      // Reset during beat 3
      step(1'b1, 32'hA5C3_96F0, 1'b0);
      idle(3);
      rst = 1'b1;
      #1;
      chk("arst_frame", 32'(tsv_frame), 32'd0);
      chk("arst_data", 32'(tsv_data), 32'd0);
      chk("arst_par", 32'(tsv_par), 32'd0);
      m_reset();
      @(posedge clk1);
      @(negedge clk1);
      rst = 1'b0;
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      send_one(32'h1357_9BDF);

      // Frame counter saturation
      force dut.frames_q = 16'hFFFE;
      #1;
      release dut.frames_q;
      m_frames = 16'hFFFE;
      for (int i = 0; i < 3; i++) send_one($urandom);
      chk("sat_frames", 32'(frames_sent), 32'h0000_FFFF);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, $urandom,
              (($urandom % 3) == 0) && (m_cred < CR));
      end
      idle(NB + 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
